// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch/decode/indirect/interrupt sequencer for a 12-bit-address, 16-bit-word machine
module instruction_fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        ien,
  input  logic        irq,
  input  logic        exec_done,
  input  logic        pc_load,
  input  logic [11:0] pc_load_val,
  input  logic        pc_skip,
  input  logic [11:0] ex_addr,
  input  logic [15:0] ex_wdata,
  input  logic        ex_we,
  output logic [15:0] ir,
  output logic [11:0] ar,
  output logic [11:0] pc,
  output logic        i_bit,
  output logic        instr_valid,
  output logic        int_ack
);

  typedef enum logic [2:0] {
    S_FETCH0, S_FETCH1, S_DECODE, S_INDIRECT, S_EXEC, S_INT0, S_INT1, S_INT2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [11:0] ar_q, ar_d;
  logic [15:0] ir_q, ir_d;
  logic [11:0] tr_q, tr_d;
  logic        i_bit_q, i_bit_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH0;
      pc_q    <= RESET_PC;
      ar_q    <= 12'h000;
      ir_q    <= 16'h0000;
      tr_q    <= 12'h000;
      i_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      tr_q    <= tr_d;
      i_bit_q <= i_bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH0:   state_d = S_FETCH1;
      S_FETCH1:   state_d = S_DECODE;
      // Opcode 111 is a register/IO instruction; its I bit selects the group, not indirection.
      S_DECODE:   state_d = (ir_q[15] && (ir_q[14:12] != 3'b111)) ? S_INDIRECT : S_EXEC;
      S_INDIRECT: state_d = S_EXEC;
      S_EXEC:     if (exec_done) state_d = (ien && irq) ? S_INT0 : S_FETCH0;
      S_INT0:     state_d = S_INT1;
      S_INT1:     state_d = S_INT2;
      S_INT2:     state_d = S_FETCH0;
      default:    state_d = S_FETCH0;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ar_d    = ar_q;
    ir_d    = ir_q;
    tr_d    = tr_q;
    i_bit_d = i_bit_q;
    case (state_q)
      S_FETCH0: ar_d = pc_q;
      S_FETCH1: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 12'd1;
      end
      S_DECODE: begin
        ar_d    = ir_q[11:0];
        i_bit_d = ir_q[15];
      end
      S_INDIRECT: ar_d = mem_rdata[11:0];
      S_EXEC: begin
        if (exec_done) begin
          if (pc_load)      pc_d = pc_load_val;
          else if (pc_skip) pc_d = pc_q + 12'd1;
        end
      end
      S_INT0: begin
        ar_d = 12'h000;
        tr_d = pc_q;
      end
      S_INT1:  pc_d = 12'h000;
      S_INT2:  pc_d = 12'h001;
      default: ;
    endcase
  end

  always_comb begin
    mem_addr    = ar_q;
    mem_wdata   = 16'h0000;
    mem_we      = 1'b0;
    instr_valid = 1'b0;
    int_ack     = 1'b0;
    case (state_q)
      S_EXEC: begin
        mem_addr    = ex_addr;
        mem_wdata   = ex_wdata;
        mem_we      = ex_we;
        instr_valid = 1'b1;
      end
      S_INT1: begin
        mem_addr  = 12'h000;
        mem_wdata = {4'h0, tr_q};
        mem_we    = 1'b1;
      end
      S_INT2:  int_ack = 1'b1;
      default: ;
    endcase
    // A write must never escape while reset is held, whatever state was left behind.
    if (reset) mem_we = 1'b0;
  end

  assign ir    = ir_q;
  assign ar    = ar_q;
  assign pc    = pc_q;
  assign i_bit = i_bit_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed table-driven bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic        ien, irq, exec_done, pc_load, pc_skip;
  logic [11:0] pc_load_val;
  logic [11:0] ex_addr;
  logic [15:0] ex_wdata;
  logic        ex_we;
  logic [15:0] ir;
  logic [11:0] ar, pc;
  logic        i_bit, instr_valid, int_ack;

  logic [15:0] mem [0:4095];
  logic        tb_we;
  logic [11:0] tb_waddr;
  logic [15:0] tb_wdata;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .ien(ien), .irq(irq), .exec_done(exec_done),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc_skip(pc_skip),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_we(ex_we),
    .ir(ir), .ar(ar), .pc(pc), .i_bit(i_bit),
    .instr_valid(instr_valid), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  typedef struct {
    logic [11:0] pc_at;
    logic [15:0] instr;
    logic        has_ind;
    logic [11:0] ind_addr;
    logic [15:0] ind_word;
    logic [11:0] exp_ar;
    logic        exp_ibit;
    int          exp_lat;
    logic [11:0] exp_pc_fetch;
    logic        ld;
    logic [11:0] ld_val;
    logic        skip;
    logic [11:0] exp_pc_after;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    tb_we = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  // Starts in FETCH0; spurious exec_done/pc_load/pc_skip are held until EXEC is reached.
  task automatic fetch_and_check(input string name, input logic [15:0] e_ir, input logic [11:0] e_ar,
                                 input logic e_ib, input int e_lat, input logic [11:0] e_pc);
    int cyc;
    exec_done = 1'b1; pc_load = 1'b1; pc_load_val = 12'hABC; pc_skip = 1'b1;
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      step();
      cyc++;
    end
    exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    chk({name, " latency"}, cyc, e_lat);
    chk({name, " ir"}, {16'h0, ir}, {16'h0, e_ir});
    chk({name, " ar"}, {20'h0, ar}, {20'h0, e_ar});
    chk({name, " i_bit"}, {31'h0, i_bit}, {31'h0, e_ib});
    chk({name, " pc"}, {20'h0, pc}, {20'h0, e_pc});
    chk({name, " exec mem_addr"}, {20'h0, mem_addr}, 32'h5A5);
    chk({name, " exec mem_wdata"}, {16'h0, mem_wdata}, 32'hBEEF);
    chk({name, " exec mem_we"}, {31'h0, mem_we}, 32'h0);
  endtask

  initial begin
    vecs[0] = '{12'h000, 16'h400F, 1'b0, 12'h000, 16'h0000, 12'h00F, 1'b0, 3, 12'h001, 1'b1, 12'h011, 1'b1, 12'h011};
    vecs[1] = '{12'h011, 16'h9016, 1'b1, 12'h016, 16'h0017, 12'h017, 1'b1, 4, 12'h012, 1'b1, 12'h020, 1'b0, 12'h020};
    vecs[2] = '{12'h020, 16'h7800, 1'b0, 12'h000, 16'h0000, 12'h800, 1'b0, 3, 12'h021, 1'b0, 12'h000, 1'b0, 12'h021};
    vecs[3] = '{12'h021, 16'hF123, 1'b0, 12'h000, 16'h0000, 12'h123, 1'b1, 3, 12'h022, 1'b1, 12'hFFE, 1'b0, 12'hFFE};
    vecs[4] = '{12'hFFE, 16'h0005, 1'b0, 12'h000, 16'h0000, 12'h005, 1'b0, 3, 12'hFFF, 1'b0, 12'h000, 1'b1, 12'h000};
    vecs[5] = '{12'h000, 16'h400F, 1'b0, 12'h000, 16'h0000, 12'h00F, 1'b0, 3, 12'h001, 1'b1, 12'hFFF, 1'b0, 12'hFFF};
    vecs[6] = '{12'hFFF, 16'h8FFE, 1'b1, 12'hFFE, 16'h0005, 12'h005, 1'b1, 4, 12'h000, 1'b1, 12'h011, 1'b0, 12'h011};

    reset = 1'b1; ien = 1'b0; irq = 1'b0; exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
    pc_load_val = 12'h000; ex_addr = 12'h5A5; ex_wdata = 16'hBEEF; ex_we = 1'b0;
    tb_we = 1'b0; tb_waddr = 12'h000; tb_wdata = 16'h0000;

    step();
    step();
    for (int i = 0; i < 7; i++) begin
      poke(vecs[i].pc_at, vecs[i].instr);
      if (vecs[i].has_ind) poke(vecs[i].ind_addr, vecs[i].ind_word);
    end
    poke(12'h001, 16'h2034);

    chk("reset mem_we", {31'h0, mem_we}, 32'h0);
    reset = 1'b0;
    chk("reset pc", {20'h0, pc}, 32'h000);
    chk("reset ar", {20'h0, ar}, 32'h000);
    chk("reset ir", {16'h0, ir}, 32'h0000);
    chk("reset i_bit", {31'h0, i_bit}, 32'h0);
    chk("reset instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("reset int_ack", {31'h0, int_ack}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      fetch_and_check($sformatf("vec%0d", i), vecs[i].instr, vecs[i].exp_ar, vecs[i].exp_ibit,
                      vecs[i].exp_lat, vecs[i].exp_pc_fetch);
      exec_done = 1'b1; pc_load = vecs[i].ld; pc_load_val = vecs[i].ld_val; pc_skip = vecs[i].skip;
      step();
      exec_done = 1'b0; pc_load = 1'b0; pc_skip = 1'b0;
      chk($sformatf("vec%0d pc after exec_done", i), {20'h0, pc}, {20'h0, vecs[i].exp_pc_after});
      chk($sformatf("vec%0d leaves exec", i), {31'h0, instr_valid}, 32'h0);
    end

    // Interrupt cycle from pc=012.
    fetch_and_check("pre-int", 16'h9016, 12'h017, 1'b1, 4, 12'h012);
    ien = 1'b1; irq = 1'b1; exec_done = 1'b1;
    step();
    exec_done = 1'b0; ien = 1'b0; irq = 1'b0;
    chk("int0 mem_we", {31'h0, mem_we}, 32'h0);
    chk("int0 int_ack", {31'h0, int_ack}, 32'h0);
    step();
    chk("int1 mem_we", {31'h0, mem_we}, 32'h1);
    chk("int1 mem_addr", {20'h0, mem_addr}, 32'h000);
    chk("int1 mem_wdata", {16'h0, mem_wdata}, 32'h0012);
    step();
    chk("int2 pc", {20'h0, pc}, 32'h000);
    chk("int2 M[000]", {16'h0, mem[0]}, 32'h0012);
    chk("int2 int_ack", {31'h0, int_ack}, 32'h1);
    step();
    chk("post-int int_ack", {31'h0, int_ack}, 32'h0);
    chk("post-int pc", {20'h0, pc}, 32'h001);
    fetch_and_check("post-int", 16'h2034, 12'h034, 1'b0, 3, 12'h002);

    // Execute-stage write passes through, and EXEC holds without exec_done.
    ex_addr = 12'h100; ex_wdata = 16'hCAFE; ex_we = 1'b1;
    #1;
    chk("exec pass mem_we", {31'h0, mem_we}, 32'h1);
    step();
    ex_we = 1'b0; ex_addr = 12'h5A5; ex_wdata = 16'hBEEF;
    chk("exec write M[100]", {16'h0, mem[12'h100]}, 32'hCAFE);
    chk("exec holds", {31'h0, instr_valid}, 32'h1);
    poke(12'h000, 16'h400F);
    chk("exec still holds", {31'h0, instr_valid}, 32'h1);

    // Reset landing in INT1 must suppress the return-address write.
    ien = 1'b1; irq = 1'b1; exec_done = 1'b1;
    step();
    exec_done = 1'b0; ien = 1'b0; irq = 1'b0;
    step();
    chk("int1b mem_we before reset", {31'h0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    chk("int1b mem_we in reset", {31'h0, mem_we}, 32'h0);
    step();
    reset = 1'b0;
    chk("int1b M[000] kept", {16'h0, mem[0]}, 32'h400F);
    chk("int1b pc", {20'h0, pc}, 32'h000);
    chk("int1b int_ack", {31'h0, int_ack}, 32'h0);
    fetch_and_check("restart", 16'h400F, 12'h00F, 1'b0, 3, 12'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
